mem_access_ctrl: RTL and testbench

Data-memory access controller for the MIPS datapath. It narrows 32-bit register data into byte-lane writes, which is the inverse of immediate widening. It also widens returned memory lanes into 32-bit load results by sign or zero extension. It sits between the ALU/register file and the data memory, and runs a req/ack handshake that tolerates multi-cycle memory latency.

---
 rtl/mem_access_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: formats byte/half/word stores into lanes, extends loads,
// and runs a req/ack handshake with a bounded wait before aborting with error.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        load_signed,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] load_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone,
        StErr
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            mw_q, mw_d;
    logic [1:0]      size_q, size_d;
    logic            sgn_q, sgn_d;
    logic [1:0]      lo_q, lo_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     ld_q, ld_d;

    logic            legal;
    logic [3:0]      fmt_be;
    logic [31:0]     fmt_wdata;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [31:0]     rd_ext;

    always_comb begin
        legal     = 1'b0;
        fmt_be    = 4'b0000;
        fmt_wdata = 32'h0;
        case (size)
            2'b00: begin
                legal     = 1'b1;
                fmt_be    = 4'b0001 << addr[1:0];
                fmt_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                legal     = ~addr[0];
                fmt_be    = addr[1] ? 4'b1100 : 4'b0011;
                fmt_wdata = {2{store_data[15:0]}};
            end
            2'b10: begin
                legal     = (addr[1:0] == 2'b00);
                fmt_be    = 4'b1111;
                fmt_wdata = store_data;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // Lane selection uses the offset latched at start, not the live addr input.
    always_comb begin
        rd_byte = 8'h0;
        case (lo_q)
            2'b00:   rd_byte = dmem_rdata[7:0];
            2'b01:   rd_byte = dmem_rdata[15:8];
            2'b10:   rd_byte = dmem_rdata[23:16];
            default: rd_byte = dmem_rdata[31:24];
        endcase
        rd_half = lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (size_q)
            2'b00:   rd_ext = {{24{sgn_q & rd_byte[7]}}, rd_byte};
            2'b01:   rd_ext = {{16{sgn_q & rd_half[15]}}, rd_half};
            default: rd_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mw_d    = mw_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        lo_d    = lo_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        ld_d    = ld_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (legal) begin
                        mw_d    = mem_write;
                        size_d  = size;
                        sgn_d   = load_signed;
                        lo_d    = addr[1:0];
                        req_d   = 1'b1;
                        we_d    = mem_write;
                        addr_d  = {addr[31:2], 2'b00};
                        be_d    = fmt_be;
                        wdata_d = mem_write ? fmt_wdata : 32'h0;
                        cnt_d   = '0;
                        state_d = StReq;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StReq: begin
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = StDone;
                    if (!mw_q) begin
                        ld_d = rd_ext;
                    end
                end else if (cnt_q == CntLast) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mw_q    <= 1'b0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            lo_q    <= 2'b00;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            ld_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mw_q    <= mw_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            lo_q    <= lo_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            ld_q    <= ld_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone) || (state_q == StErr);
    assign error      = (state_q == StErr);
    assign load_data  = ld_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: expected completions are queued at stimulus time
// and popped when done is seen.
module tb_mem_access_ctrl;

    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mem_write;
    logic [1:0]  size;
    logic        load_signed;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] load_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    mem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mem_write  (mem_write),
        .size       (size),
        .load_signed(load_signed),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .load_data  (load_data),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] ld;
        int          lat;
        int          reqs;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_ld = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " error"}, error, 0);
        chk({tag, " load_data"}, load_data, 0);
        chk({tag, " dmem_req"}, dmem_req, 0);
        chk({tag, " dmem_we"}, dmem_we, 0);
        chk({tag, " dmem_addr"}, dmem_addr, 0);
        chk({tag, " dmem_be"}, dmem_be, 0);
        chk({tag, " dmem_wdata"}, dmem_wdata, 0);
    endtask

    // ack_at: REQ cycle (1-based) in which ack is driven, 0 = never.
    // restart_at: cycle in which a stray start is pulsed, 0 = none.
    task automatic run_access(input string tag, input logic mw, input logic [1:0] sz,
                              input logic sgn, input logic [31:0] a, input logic [31:0] sd,
                              input logic [31:0] rd, input int ack_at, input int restart_at);
        logic        lg;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] lane;
        exp_t        e;
        exp_t        got;
        int          cyc;
        int          reqs;

        lg = (sz == 2'b00) || (sz == 2'b01 && !a[0]) || (sz == 2'b10 && a[1:0] == 2'b00);
        e_be = (sz == 2'b00) ? (4'b0001 << a[1:0]) :
               (sz == 2'b01) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        e_wd = !mw ? 32'h0 :
               (sz == 2'b00) ? {4{sd[7:0]}} :
               (sz == 2'b01) ? {2{sd[15:0]}} : sd;
        if (lg && !mw && ack_at > 0) begin
            if (sz == 2'b00) begin
                lane = (rd >> (8 * a[1:0])) & 32'hFF;
                if (sgn && lane[7]) lane = lane | 32'hFFFF_FF00;
            end else if (sz == 2'b01) begin
                lane = (rd >> (16 * a[1])) & 32'hFFFF;
                if (sgn && lane[15]) lane = lane | 32'hFFFF_0000;
            end else begin
                lane = rd;
            end
            model_ld = lane;
        end
        e.err  = !lg || (ack_at == 0);
        e.ld   = model_ld;
        e.lat  = !lg ? 1 : (ack_at > 0 ? ack_at + 1 : T + 1);
        e.reqs = !lg ? 0 : (ack_at > 0 ? ack_at : T);
        sb_q.push_back(e);

        @(negedge clk);
        start = 1'b1; mem_write = mw; size = sz; load_signed = sgn; addr = a; store_data = sd;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        reqs = 0;
        if (lg) begin
            chk({tag, " dmem_req"}, dmem_req, 1);
            chk({tag, " dmem_addr"}, dmem_addr, {a[31:2], 2'b00});
            chk({tag, " dmem_be"}, dmem_be, e_be);
            chk({tag, " dmem_we"}, dmem_we, mw);
            chk({tag, " dmem_wdata"}, dmem_wdata, e_wd);
        end
        while (done !== 1'b1 && cyc < 40) begin
            if (dmem_req === 1'b1) reqs++;
            if (lg && cyc == ack_at) begin
                dmem_ack = 1'b1;
                dmem_rdata = rd;
            end
            if (cyc == restart_at) start = 1'b1;
            @(negedge clk);
            dmem_ack = 1'b0;
            start = 1'b0;
            cyc++;
        end
        if (sb_q.size() == 0) begin
            chk({tag, " scoreboard empty"}, 1, 0);
        end else begin
            got = sb_q.pop_front();
            chk({tag, " done"}, done, 1);
            chk({tag, " error"}, error, got.err);
            chk({tag, " load_data"}, load_data, got.ld);
            chk({tag, " latency"}, cyc, got.lat);
            chk({tag, " req cycles"}, reqs, got.reqs);
            chk({tag, " req low at done"}, dmem_req, 0);
        end
        @(negedge clk);
        chk({tag, " busy after"}, busy, 0);
        chk({tag, " done after"}, done, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mem_write = 1'b0; size = 2'b00; load_signed = 1'b0;
        addr = 32'h0; store_data = 32'h0; dmem_rdata = 32'h0; dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        run_access("ld_byte_s", 1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 3, 0);
        run_access("ld_half_u", 1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 32'h9ABC_1234, 1, 0);
        run_access("st_byte", 1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h1234_56A5, 32'hFFFF_FFFF, 2, 0);
        run_access("ld_word_mis", 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 1, 0);
        run_access("ld_size11", 1'b0, 2'b11, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 1, 0);
        run_access("st_half_mis", 1'b1, 2'b01, 1'b0, 32'h0000_0101, 32'hCAFE_F00D, 32'h0, 1, 0);
        run_access("timeout", 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 0, 2);
        for (int i = 0; i < 3; i++) begin
            chk("no second txn req", dmem_req, 0);
            chk("no second txn busy", busy, 0);
            @(negedge clk);
        end
        run_access("ld_half_s", 1'b0, 2'b01, 1'b1, 32'h0000_0300, 32'h0, 32'h7777_8001, 2, 0);
        run_access("st_half_hi", 1'b1, 2'b01, 1'b0, 32'h0000_0302, 32'h0102_BEEF, 32'h0, 1, 0);
        run_access("st_word", 1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'h0BAD_CAFE, 32'h0, 1, 0);
        run_access("ld_byte_u", 1'b0, 2'b00, 1'b0, 32'h0000_0502, 32'h0, 32'h11F2_3344, 1, 0);

        // Stray ack while idle must not start anything.
        @(negedge clk);
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("idle ack busy", busy, 0);
        chk("idle ack done", done, 0);
        chk("idle ack load_data", load_data, model_ld);

        // Reset during REQ aborts silently.
        start = 1'b1; mem_write = 1'b0; size = 2'b10; addr = 32'h0000_0020;
        @(negedge clk);
        start = 1'b0;
        chk("pre-reset req", dmem_req, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_ld = 32'h0;
        chk_all_zero("mid reset");
        for (int i = 0; i < 3; i++) begin
            chk("post reset done", done, 0);
            chk("post reset req", dmem_req, 0);
            @(negedge clk);
        end
        run_access("ld_word_after_rst", 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,
                   32'hDEAD_BEEF, 2, 0);
        chk("final load_data", load_data, 32'hDEAD_BEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
